// File: rtl/dma_reg_pkg.sv
// dma_reg_pkg: shared types and constants for the DMA register-bus arbiter.
//   arb_state_e         - sequencer states (IDLE, ISSUE, WAIT, RESP)
//   DMA_ADDR_W/DATA_W   - default register address/data widths
//   RD_LAT_MAX          - largest supported read latency
//   LAT_CNT_W           - width of the read-latency counter
package dma_reg_pkg;

  localparam int unsigned DMA_ADDR_W = 32;
  localparam int unsigned DMA_DATA_W = 32;
  localparam int unsigned RD_LAT_MAX = 8;
  localparam int unsigned LAT_CNT_W  = $clog2(RD_LAT_MAX + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_e;

endpackage

// File: rtl/dma_reg_arbiter_rr.sv
// rr_arbiter: combinational round-robin arbiter, reusable by any DMA channel.
//   req        in  N      request vector
//   last_grant in  IDX_W  index granted last time; search starts one above it
//   grant      out N      one-hot grant (zero when nothing requests)
//   grant_idx  out IDX_W  index of the granted requester
//   any        out 1      at least one request present
module rr_arbiter
  import dma_reg_pkg::*;
#(
  parameter int unsigned N     = 4,
  parameter int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] last_grant,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             any
);

  logic [IDX_W-1:0] cand;

  // Circular successor of base by off positions, always inside 0..N-1.
  function automatic logic [IDX_W-1:0] wrap_idx(input logic [IDX_W-1:0] base,
                                                input int unsigned      off);
    int unsigned s;
    s = (32'(base) + off) % N;
    return IDX_W'(s);
  endfunction

  // First requester found walking last_grant+1, +2, ... wraps back to last_grant.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    cand      = '0;
    for (int unsigned off = 1; off <= N; off++) begin
      cand = wrap_idx(last_grant, off);
      if (!any && req[cand]) begin
        any       = 1'b1;
        grant_idx = cand;
      end
    end
    grant[grant_idx] = any;
  end

endmodule

// File: rtl/dma_reg_arbiter.sv
// dma_reg_arbiter: shares one DMA register port among NUM_REQ requesters.
// Round-robin picks a winner in IDLE, the transaction is issued as a single
// valid beat, reads wait RD_LAT cycles for rdata, and a one-cycle rsp_valid
// pulse is returned to the owning requester.
//   clk, reset             clock, asynchronous active-high reset
//   req_valid/req_wr_en    per-requester request and direction (1 = write)
//   req_addr/req_wdata     packed per-requester payloads (i*W +: W)
//   req_ready              one-hot accept strobe, combinational, IDLE only
//   rsp_valid/rsp_rdata    one-hot completion pulse and shared read data
//   busy                   state is not IDLE
//   addr/wr_en/valid/wdata register-bus request side
//   rdata                  register-bus read data
module dma_reg_arbiter
  import dma_reg_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ADDR_W  = DMA_ADDR_W,
  parameter int unsigned DATA_W  = DMA_DATA_W,
  parameter int unsigned RD_LAT  = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_wr_en,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic                      busy,
  output logic [ADDR_W-1:0]         addr,
  output logic                      wr_en,
  output logic                      valid,
  output logic [DATA_W-1:0]         wdata,
  input  logic [DATA_W-1:0]         rdata
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  arb_state_e             state_q, state_d;
  logic [IDX_W-1:0]       last_grant_q;
  logic [IDX_W-1:0]       owner_q;
  logic [LAT_CNT_W-1:0]   cnt_q;

  logic [NUM_REQ-1:0]     grant;
  logic [IDX_W-1:0]       grant_idx;
  logic                   grant_any;
  logic                   accept;
  logic                   lat_done;
  logic [NUM_REQ-1:0]     rsp_vec;

  logic [ADDR_W-1:0]      addr_arr  [NUM_REQ];
  logic [DATA_W-1:0]      wdata_arr [NUM_REQ];

  always_comb begin
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      addr_arr[i]  = req_addr[i*ADDR_W +: ADDR_W];
      wdata_arr[i] = req_wdata[i*DATA_W +: DATA_W];
    end
  end

  rr_arbiter #(
    .N     (NUM_REQ),
    .IDX_W (IDX_W)
  ) u_rr (
    .req        (req_valid),
    .last_grant (last_grant_q),
    .grant      (grant),
    .grant_idx  (grant_idx),
    .any        (grant_any)
  );

  // reset gates req_ready directly so nothing is offered while it is held.
  always_comb begin
    req_ready = '0;
    if (state_q == IDLE && !reset && grant_any) req_ready = grant;
  end

  assign accept   = |(req_valid & req_ready);
  assign lat_done = (cnt_q <= LAT_CNT_W'(1));

  always_comb begin
    rsp_vec          = '0;
    rsp_vec[owner_q] = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = ISSUE;
      ISSUE:   state_d = wr_en ? RESP : WAIT;
      WAIT:    if (lat_done) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // valid, rsp_valid and busy are registered from state_d so they line up
  // with the state they describe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant_q <= IDX_W'(NUM_REQ - 1);
      owner_q      <= '0;
      cnt_q        <= '0;
      valid        <= 1'b0;
      wr_en        <= 1'b0;
      addr         <= '0;
      wdata        <= '0;
      rsp_valid    <= '0;
      rsp_rdata    <= '0;
      busy         <= 1'b0;
    end else begin
      valid     <= (state_d == ISSUE);
      busy      <= (state_d != IDLE);
      rsp_valid <= (state_d == RESP) ? rsp_vec : '0;

      if (accept) begin
        wr_en        <= req_wr_en[grant_idx];
        addr         <= addr_arr[grant_idx];
        wdata        <= wdata_arr[grant_idx];
        owner_q      <= grant_idx;
        last_grant_q <= grant_idx;
      end

      if (state_q == ISSUE && !wr_en) begin
        cnt_q <= LAT_CNT_W'(RD_LAT);
      end else if (state_q == WAIT) begin
        cnt_q <= cnt_q - LAT_CNT_W'(1);
        if (lat_done) rsp_rdata <= rdata;
      end
    end
  end

endmodule

// File: tb/tb_dma_reg_arbiter.sv
module tb_dma_reg_arbiter;

  localparam int unsigned NR  = 4;
  localparam int unsigned AW  = 32;
  localparam int unsigned DW  = 32;
  localparam int unsigned LAT = 3;
  localparam logic [31:0] BAD = 32'hBAD0_0BAD;

  logic              clk = 1'b0;
  logic              reset;
  logic [NR-1:0]     req_valid;
  logic [NR-1:0]     req_wr_en;
  logic [NR*AW-1:0]  req_addr;
  logic [NR*DW-1:0]  req_wdata;
  logic [NR-1:0]     req_ready;
  logic [NR-1:0]     rsp_valid;
  logic [DW-1:0]     rsp_rdata;
  logic              busy;
  logic [AW-1:0]     addr;
  logic              wr_en;
  logic              valid;
  logic [DW-1:0]     wdata;
  logic [DW-1:0]     rdata;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  always #5 clk = ~clk;

  dma_reg_arbiter #(
    .NUM_REQ (NR),
    .ADDR_W  (AW),
    .DATA_W  (DW),
    .RD_LAT  (LAT)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_wr_en (req_wr_en),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .busy      (busy),
    .addr      (addr),
    .wr_en     (wr_en),
    .valid     (valid),
    .wdata     (wdata),
    .rdata     (rdata)
  );

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic set_req(input int unsigned i, input logic wr, input logic [31:0] a,
                         input logic [31:0] d);
    req_wr_en[i]        = wr;
    req_addr[i*AW +: AW]  = a;
    req_wdata[i*DW +: DW] = d;
  endtask

  initial begin
    int unsigned pulses;
    logic [NR-1:0] rsp_or;
    logic [NR-1:0] exp_oh;

    reset     = 1'b1;
    req_valid = '1;
    req_wr_en = '0;
    req_addr  = '0;
    req_wdata = '0;
    rdata     = BAD;

    // Reset state, with every requester asserting
    #2; settle();
    check_val("rst_ready", req_ready, 0);
    check_val("rst_valid", valid, 0);
    check_val("rst_busy", busy, 0);
    check_val("rst_rsp_valid", rsp_valid, 0);
    check_val("rst_rsp_rdata", rsp_rdata, 0);
    check_val("rst_addr", addr, 0);

    step(); step();
    reset     = 1'b0;
    req_valid = '0;
    set_req(0, 1'b1, 32'h10, 32'hDEAD_BEEF);

    // Single write from req0
    step();
    req_valid = 4'b0001; settle();
    check_val("wr_ready", req_ready, 4'b0001);
    check_val("wr_busy_idle", busy, 0);
    step(); req_valid = '0; settle();
    check_val("wr_valid", valid, 1);
    check_val("wr_wr_en", wr_en, 1);
    check_val("wr_addr", addr, 32'h10);
    check_val("wr_wdata", wdata, 32'hDEAD_BEEF);
    check_val("wr_busy", busy, 1);
    check_val("wr_rsp_early", rsp_valid, 0);
    step(); settle();
    check_val("wr_valid_once", valid, 0);
    check_val("wr_rsp", rsp_valid, 4'b0001);
    check_val("wr_ready_resp", req_ready, 0);
    step(); settle();
    check_val("wr_rsp_once", rsp_valid, 0);
    check_val("wr_busy_done", busy, 0);

    // Read from req2, slave data present only in T+4
    set_req(2, 1'b0, 32'h24, 32'h0);
    req_valid = 4'b0100; settle();
    check_val("rd_ready", req_ready, 4'b0100);
    step(); req_valid = '0; settle();
    check_val("rd_valid", valid, 1);
    check_val("rd_wr_en", wr_en, 0);
    check_val("rd_addr", addr, 32'h24);
    step(); settle();
    check_val("rd_rsp_t2", rsp_valid, 0);
    step(); settle();
    check_val("rd_rsp_t3", rsp_valid, 0);
    step(); rdata = 32'hCAFE_0001; settle();
    check_val("rd_rsp_t4", rsp_valid, 0);
    step(); rdata = BAD; settle();
    check_val("rd_rsp", rsp_valid, 4'b0100);
    check_val("rd_rdata", rsp_rdata, 32'hCAFE_0001);
    step(); settle();
    check_val("rd_rsp_once", rsp_valid, 0);
    check_val("rd_rdata_hold", rsp_rdata, 32'hCAFE_0001);

    // Read from req3 aborted by reset in WAIT
    set_req(3, 1'b0, 32'h30, 32'h0);
    req_valid = 4'b1000; settle();
    check_val("ab_ready", req_ready, 4'b1000);
    step(); req_valid = '0;
    step(); settle();
    check_val("ab_busy_wait", busy, 1);
    #2;
    reset     = 1'b1;
    req_valid = '1;
    #1;
    check_val("ab_valid", valid, 0);
    check_val("ab_rsp_valid", rsp_valid, 0);
    check_val("ab_busy", busy, 0);
    check_val("ab_rsp_rdata", rsp_rdata, 0);
    check_val("ab_ready", req_ready, 0);

    // All four hold req_valid: expect 0,1,2,3,0 after reset release
    step();
    for (int unsigned i = 0; i < NR; i++) set_req(i, 1'b1, 32'h100 + i, 32'h5000 + i);
    reset = 1'b0; settle();
    for (int unsigned k = 0; k < 5; k++) begin
      exp_oh = '0;
      exp_oh[k % NR] = 1'b1;
      check_val($sformatf("rr_ready_%0d", k), req_ready, exp_oh);
      check_val($sformatf("rr_norsp_%0d", k), rsp_valid, 0);
      step(); settle();
      check_val($sformatf("rr_addr_%0d", k), addr, 32'h100 + (k % NR));
      check_val($sformatf("rr_busy_ready_%0d", k), req_ready, 0);
      step(); settle();
      check_val($sformatf("rr_rsp_%0d", k), rsp_valid, exp_oh);
      check_val($sformatf("rr_resp_ready_%0d", k), req_ready, 0);
      step(); settle();
    end
    req_valid = '0; settle();

    // Move last_grant to 3, then req1 and req3 compete
    set_req(3, 1'b1, 32'h300, 32'h33);
    req_valid = 4'b1000; settle();
    check_val("wp_pre_ready", req_ready, 4'b1000);
    step(); req_valid = '0;
    step(); step(); settle();
    set_req(1, 1'b1, 32'h210, 32'h11);
    req_valid = 4'b1010; settle();
    check_val("wp_first", req_ready, 4'b0010);
    step(); req_valid = 4'b1000; settle();
    check_val("wp_first_addr", addr, 32'h210);
    step(); step(); settle();
    check_val("wp_second", req_ready, 4'b1000);
    step(); req_valid = '0; settle();
    check_val("wp_second_addr", addr, 32'h300);
    step(); step(); settle();

    // req1 withdraws in the cycle req0 is accepted
    set_req(0, 1'b1, 32'h400, 32'h44);
    set_req(1, 1'b1, 32'h410, 32'h55);
    req_valid = 4'b0011; settle();
    check_val("wd_ready", req_ready, 4'b0001);
    step(); req_valid = '0; settle();
    pulses = 0;
    rsp_or = '0;
    for (int unsigned c = 0; c < 8; c++) begin
      if (valid) pulses++;
      rsp_or = rsp_or | rsp_valid;
      step(); settle();
    end
    check_val("wd_valid_pulses", pulses, 1);
    check_val("wd_rsp_seen", rsp_or, 4'b0001);
    check_val("wd_last_addr", addr, 32'h400);
    check_val("wd_idle_busy", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
